// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, default payload width and parity modes.
// Used by both the transmitter and the receiver side.
package uart_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_START  = 3'd1;
  localparam state_t ST_DATA   = 3'd2;
  localparam state_t ST_PARITY = 3'd3;
  localparam state_t ST_STOP   = 3'd4;

  localparam int DEFAULT_DATA_BITS = 8;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;

  // A zero divisor would never end a bit; treat it as one cycle per bit.
  function automatic logic [15:0] safe_div(input logic [15:0] d);
    return (d == 16'd0) ? 16'd1 : d;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous show-ahead FIFO for the transmit path; full/empty are registered flags.
module uart_tx_fifo #(
  parameter int DATA_BITS = 8,
  parameter int DEPTH     = 4
) (
  input  logic                 sysclk,
  input  logic                 reset,
  input  logic                 wr_en,
  input  logic [DATA_BITS-1:0] wr_data,
  input  logic                 rd_en,
  output logic [DATA_BITS-1:0] rd_data,
  output logic                 full,
  output logic                 empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_INC  = AW'(1);
  localparam logic [AW:0]   CNT_INC  = (AW+1)'(1);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

  logic [DATA_BITS-1:0] r_mem [DEPTH];
  logic [AW-1:0]        r_wr_ptr;
  logic [AW-1:0]        r_rd_ptr;
  logic [AW:0]          r_count;
  logic                 r_full;
  logic                 r_empty;
  logic                 w_push;
  logic                 w_pop;
  logic [AW:0]          w_count_nxt;

  // A write while full is dropped even if a pop frees a slot this cycle.
  assign w_push = wr_en && !r_full;
  assign w_pop  = rd_en && !r_empty;

  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop)
      w_count_nxt = r_count + CNT_INC;
    else if (!w_push && w_pop)
      w_count_nxt = r_count - CNT_INC;
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_INC;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_INC;
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == FULL_CNT);
      r_empty <= (w_count_nxt == '0);
    end
  end

  always_ff @(posedge sysclk) begin
    if (w_push) r_mem[r_wr_ptr] <= wr_data;
  end

  assign rd_data = r_mem[r_rd_ptr];
  assign full    = r_full;
  assign empty   = r_empty;

endmodule

// File: rtl/uart_tx_framed.sv
// Buffered UART transmitter: start, LSB-first data, optional even parity, stop.
// Bit timing comes from a divisor latched at each frame start.
module uart_tx_framed
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = DEFAULT_DATA_BITS,
  parameter int FIFO_DEPTH = 4,
  parameter int PARITY_EN  = 1
) (
  input  logic                 sysclk,
  input  logic                 reset,
  input  logic [15:0]          divisor,
  input  logic                 wr_en,
  input  logic [DATA_BITS-1:0] wr_data,
  output logic                 full,
  output logic                 empty,
  output logic                 busy,
  output logic                 tx_data_out
);

  localparam int BCW         = $clog2(DATA_BITS + 1);
  localparam int PARITY_MODE = (PARITY_EN != 0) ? PARITY_EVEN : PARITY_NONE;
  localparam bit USE_PARITY  = (PARITY_MODE == PARITY_EVEN);
  localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_BITS - 1);
  localparam logic [BCW-1:0] BIT_INC  = BCW'(1);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [15:0]          r_baud_cnt;
  logic [15:0]          r_div;
  logic [BCW-1:0]       r_bit_cnt;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_parity;
  logic                 r_tx;
  logic                 w_bit_end;
  logic                 w_pop;
  logic                 w_line;
  logic                 w_busy;
  logic [DATA_BITS-1:0] w_fifo_data;
  logic                 w_full;
  logic                 w_empty;

  uart_tx_fifo #(
    .DATA_BITS(DATA_BITS),
    .DEPTH    (FIFO_DEPTH)
  ) u_fifo (
    .sysclk (sysclk),
    .reset  (reset),
    .wr_en  (wr_en),
    .wr_data(wr_data),
    .rd_en  (w_pop),
    .rd_data(w_fifo_data),
    .full   (w_full),
    .empty  (w_empty)
  );

  assign w_bit_end = (r_baud_cnt == r_div - 16'd1);

  always_ff @(posedge sysclk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (!w_empty) w_state_nxt = ST_START;
      ST_START:  if (w_bit_end) w_state_nxt = ST_DATA;
      ST_DATA:   if (w_bit_end && (r_bit_cnt == LAST_BIT))
                   w_state_nxt = USE_PARITY ? ST_PARITY : ST_STOP;
      ST_PARITY: if (w_bit_end) w_state_nxt = ST_STOP;
      ST_STOP:   if (w_bit_end) w_state_nxt = w_empty ? ST_IDLE : ST_START;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_line = 1'b1;
    case (r_state)
      ST_START:  w_line = 1'b0;
      ST_DATA:   w_line = r_shift[0];
      ST_PARITY: w_line = r_parity;
      default:   w_line = 1'b1;
    endcase
    w_busy = (r_state != ST_IDLE);
    w_pop  = !w_empty && ((r_state == ST_IDLE) || ((r_state == ST_STOP) && w_bit_end));
  end

  // Control: baud and bit counters plus the registered line.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      r_baud_cnt <= '0;
      r_bit_cnt  <= '0;
      r_tx       <= 1'b1;
    end else begin
      r_tx <= w_line;
      if (w_pop) begin
        r_baud_cnt <= '0;
        r_bit_cnt  <= '0;
      end else if (r_state != ST_IDLE) begin
        if (w_bit_end) begin
          r_baud_cnt <= '0;
          if (r_state == ST_DATA) r_bit_cnt <= r_bit_cnt + BIT_INC;
        end else begin
          r_baud_cnt <= r_baud_cnt + 16'd1;
        end
      end
    end
  end

  // Datapath: frame payload, its parity and the bit period are captured at pop.
  always_ff @(posedge sysclk) begin
    if (w_pop) begin
      r_shift  <= w_fifo_data;
      r_parity <= ^w_fifo_data;
      r_div    <= safe_div(divisor);
    end else if ((r_state == ST_DATA) && w_bit_end) begin
      r_shift <= r_shift >> 1;
    end
  end

  assign full        = w_full;
  assign empty       = w_empty;
  assign busy        = w_busy;
  assign tx_data_out = r_tx;

endmodule

// File: tb/tb_uart_tx_framed.sv
// Directed bench for uart_tx_framed: one task per scenario, hand-computed frame images.
module tb_uart_tx_framed;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] divisor = 16'd4;
  logic        wr_en = 1'b0;
  logic [7:0]  wr_data = 8'h00;
  logic        full1, empty1, busy1, tx1;
  logic [15:0] divisor2 = 16'd1;
  logic        wr_en2 = 1'b0;
  logic [7:0]  wr_data2 = 8'h00;
  logic        full2, empty2, busy2, tx2;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_framed #(.DATA_BITS(8), .FIFO_DEPTH(4), .PARITY_EN(1)) dut (
    .sysclk(clk), .reset(rst), .divisor(divisor), .wr_en(wr_en), .wr_data(wr_data),
    .full(full1), .empty(empty1), .busy(busy1), .tx_data_out(tx1)
  );

  uart_tx_framed #(.DATA_BITS(8), .FIFO_DEPTH(4), .PARITY_EN(0)) dut_np (
    .sysclk(clk), .reset(rst), .divisor(divisor2), .wr_en(wr_en2), .wr_data(wr_data2),
    .full(full2), .empty(empty2), .busy(busy2), .tx_data_out(tx2)
  );

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_idle;
    bit ok = 0;
    for (int t = 0; t < 2000; t++) begin
      @(negedge clk);
      if (!busy1 && empty1 && !busy2 && empty2) begin ok = 1; break; end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL wait_idle: busy1=%b empty1=%b busy2=%b empty2=%b, required idle", busy1, empty1, busy2, empty2);
    end
  endtask

  // Finds the next start bit and samples each bit near its centre.
  task automatic capture(input int div, input int nb, input bit sel2,
                         output logic [10:0] bits, output int start_cyc);
    bit found = 0;
    int off = 0;
    int target;
    bits = '1;
    start_cyc = 0;
    for (int t = 0; t < 400; t++) begin
      @(negedge clk);
      if ((sel2 ? tx2 : tx1) == 1'b0) begin found = 1; break; end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL capture_start: line stayed %b for 400 cycles, required a 0 start bit", sel2 ? tx2 : tx1);
      return;
    end
    start_cyc = cyc;
    for (int i = 0; i < nb; i++) begin
      target = i * div + div / 2;
      repeat (target - off) @(negedge clk);
      off = target;
      bits[i] = sel2 ? tx2 : tx1;
    end
    repeat (nb * div - 1 - off) @(negedge clk);
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (tx1 !== 1'b1)    begin errors++; $display("FAIL reset_tx: got %b want 1", tx1); end
    checks++; if (busy1 !== 1'b0)  begin errors++; $display("FAIL reset_busy: got %b want 0", busy1); end
    checks++; if (full1 !== 1'b0)  begin errors++; $display("FAIL reset_full: got %b want 0", full1); end
    checks++; if (empty1 !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b want 1", empty1); end
    checks++; if (tx2 !== 1'b1)    begin errors++; $display("FAIL reset_tx2: got %b want 1", tx2); end
    checks++; if (empty2 !== 1'b1) begin errors++; $display("FAIL reset_empty2: got %b want 1", empty2); end
    rst = 1'b0;
  endtask

  task automatic test_single_frame;
    logic [10:0] exp_f = 11'b1_0_1010_0101_0;
    int busy_cnt = 0;
    logic want;
    wait_idle();
    divisor = 16'd4;
    @(posedge clk); #1 wr_en = 1'b1; wr_data = 8'hA5;
    @(posedge clk); #1 wr_en = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      want = (k >= 2 && k <= 45) ? exp_f[(k - 2) / 4] : 1'b1;
      checks++;
      if (tx1 !== want) begin errors++; $display("FAIL a5_line k=%0d: got %b want %b", k, tx1, want); end
      if (busy1) busy_cnt++;
    end
    checks++;
    if (busy_cnt != 44) begin errors++; $display("FAIL a5_busy_cycles: got %0d want 44", busy_cnt); end
  endtask

  task automatic test_back_to_back;
    logic [10:0] g1, g2;
    int s1, s2;
    wait_idle();
    divisor = 16'd2;
    @(posedge clk); #1 wr_en = 1'b1; wr_data = 8'h01;
    @(posedge clk); #1 wr_data = 8'h03;
    @(posedge clk); #1 wr_en = 1'b0;
    fork
      begin
        capture(2, 11, 1'b0, g1, s1);
        capture(2, 11, 1'b0, g2, s2);
      end
      begin
        bit seen = 0;
        for (int t = 0; t < 100; t++) begin
          @(negedge clk);
          if (tx1 == 1'b0) begin seen = 1; break; end
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL b2b_start: line %b, required 0 within 100 cycles", tx1); end
        repeat (2) @(negedge clk);
        checks++; if (empty1 !== 1'b0) begin errors++; $display("FAIL b2b_empty_mid: got %b want 0", empty1); end
        repeat (20) @(negedge clk);
        checks++; if (tx1 !== 1'b0)    begin errors++; $display("FAIL b2b_second_start: got %b want 0", tx1); end
        checks++; if (empty1 !== 1'b1) begin errors++; $display("FAIL b2b_empty_after_pop: got %b want 1", empty1); end
        checks++; if (busy1 !== 1'b1)  begin errors++; $display("FAIL b2b_busy: got %b want 1", busy1); end
      end
    join
    checks++; if (g1 !== 11'b1_1_0000_0001_0) begin errors++; $display("FAIL b2b_frame01: got %b want %b", g1, 11'b1_1_0000_0001_0); end
    checks++; if (g2 !== 11'b1_0_0000_0011_0) begin errors++; $display("FAIL b2b_frame03: got %b want %b", g2, 11'b1_0_0000_0011_0); end
    checks++; if (s2 - s1 != 22) begin errors++; $display("FAIL b2b_gap: got %0d want 22", s2 - s1); end
  endtask

  task automatic test_fifo_full;
    logic [7:0]  b3 [5] = '{8'h11, 8'h80, 8'h7F, 8'hC3, 8'hEE};
    logic [10:0] ex3 [5] = '{11'b1_0_0011_1100_0, 11'b1_0_0001_0001_0, 11'b1_1_1000_0000_0,
                             11'b1_1_0111_1111_0, 11'b1_0_1100_0011_0};
    int lows = 0;
    wait_idle();
    divisor = 16'd2;
    fork
      begin
        @(posedge clk); #1 wr_en = 1'b1; wr_data = 8'h3C;
        @(posedge clk); #1 wr_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
          wr_en = 1'b1; wr_data = b3[i];
          @(posedge clk);
          @(negedge clk);
          checks++;
          if (full1 !== (i >= 3)) begin errors++; $display("FAIL full_after_write%0d: got %b want %b", i + 1, full1, (i >= 3)); end
        end
        wr_en = 1'b0;
      end
      begin
        logic [10:0] got;
        int sc;
        for (int f = 0; f < 5; f++) begin
          capture(2, 11, 1'b0, got, sc);
          checks++;
          if (got !== ex3[f]) begin errors++; $display("FAIL full_frame%0d: got %b want %b", f, got, ex3[f]); end
        end
      end
    join
    repeat (40) begin
      @(negedge clk);
      if (tx1 == 1'b0) lows++;
    end
    checks++; if (lows != 0)       begin errors++; $display("FAIL full_extra_frame: low samples %0d want 0", lows); end
    checks++; if (busy1 !== 1'b0)  begin errors++; $display("FAIL full_final_busy: got %b want 0", busy1); end
    checks++; if (empty1 !== 1'b1) begin errors++; $display("FAIL full_final_empty: got %b want 1", empty1); end
  endtask

  task automatic test_divisor;
    logic [10:0] exp_f = 11'b1_0_0101_1010_0;
    logic [10:0] g1, g2;
    int s1, s2;
    int busy_cnt = 0;
    logic want;
    wait_idle();
    divisor = 16'd0;
    @(posedge clk); #1 wr_en = 1'b1; wr_data = 8'h5A;
    @(posedge clk); #1 wr_en = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      want = (k >= 2 && k <= 12) ? exp_f[k - 2] : 1'b1;
      checks++;
      if (tx1 !== want) begin errors++; $display("FAIL div0_line k=%0d: got %b want %b", k, tx1, want); end
      if (busy1) busy_cnt++;
    end
    checks++;
    if (busy_cnt != 11) begin errors++; $display("FAIL div0_busy_cycles: got %0d want 11", busy_cnt); end

    wait_idle();
    divisor = 16'd3;
    @(posedge clk); #1 wr_en = 1'b1; wr_data = 8'h96;
    @(posedge clk); #1 wr_data = 8'h2A;
    @(posedge clk); #1 wr_en = 1'b0;
    fork
      begin
        capture(3, 11, 1'b0, g1, s1);
        capture(5, 11, 1'b0, g2, s2);
      end
      begin
        for (int t = 0; t < 100; t++) begin
          @(negedge clk);
          if (tx1 == 1'b0) break;
        end
        repeat (4) @(negedge clk);
        divisor = 16'd5;
      end
    join
    checks++; if (g1 !== 11'b1_0_1001_0110_0) begin errors++; $display("FAIL div3_frame: got %b want %b", g1, 11'b1_0_1001_0110_0); end
    checks++; if (g2 !== 11'b1_1_0010_1010_0) begin errors++; $display("FAIL div5_frame: got %b want %b", g2, 11'b1_1_0010_1010_0); end
    checks++; if (s2 - s1 != 33) begin errors++; $display("FAIL div_change_gap: got %0d want 33", s2 - s1); end
  endtask

  task automatic test_reset_midframe;
    int lows = 0;
    int busy_cnt = 0;
    wait_idle();
    divisor = 16'd4;
    @(posedge clk); #1 wr_en = 1'b1; wr_data = 8'h55;
    @(posedge clk); #1 wr_data = 8'hAA;
    @(posedge clk); #1 wr_data = 8'h0F;
    @(posedge clk); #1 wr_en = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk);
    checks++; if (busy1 !== 1'b1)  begin errors++; $display("FAIL rstmid_busy_before: got %b want 1", busy1); end
    checks++; if (empty1 !== 1'b0) begin errors++; $display("FAIL rstmid_empty_before: got %b want 0", empty1); end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++; if (tx1 !== 1'b1)    begin errors++; $display("FAIL rstmid_tx: got %b want 1", tx1); end
    checks++; if (busy1 !== 1'b0)  begin errors++; $display("FAIL rstmid_busy: got %b want 0", busy1); end
    checks++; if (empty1 !== 1'b1) begin errors++; $display("FAIL rstmid_empty: got %b want 1", empty1); end
    checks++; if (full1 !== 1'b0)  begin errors++; $display("FAIL rstmid_full: got %b want 0", full1); end
    rst = 1'b0;
    repeat (60) begin
      @(negedge clk);
      if (tx1 == 1'b0) lows++;
      if (busy1) busy_cnt++;
    end
    checks++; if (lows != 0)     begin errors++; $display("FAIL rstmid_no_frames: low samples %0d want 0", lows); end
    checks++; if (busy_cnt != 0) begin errors++; $display("FAIL rstmid_no_busy: busy samples %0d want 0", busy_cnt); end
  endtask

  task automatic test_no_parity;
    logic [9:0]  exp_f = 10'b1_1111_1111_0;
    logic [10:0] got;
    int sc;
    int busy_cnt = 0;
    logic want;
    wait_idle();
    divisor2 = 16'd1;
    @(posedge clk); #1 wr_en2 = 1'b1; wr_data2 = 8'hFF;
    @(posedge clk); #1 wr_en2 = 1'b0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      want = (k >= 2 && k <= 11) ? exp_f[k - 2] : 1'b1;
      checks++;
      if (tx2 !== want) begin errors++; $display("FAIL np_ff_line k=%0d: got %b want %b", k, tx2, want); end
      if (busy2) busy_cnt++;
    end
    checks++;
    if (busy_cnt != 10) begin errors++; $display("FAIL np_busy_cycles: got %0d want 10", busy_cnt); end
    wait_idle();
    @(posedge clk); #1 wr_en2 = 1'b1; wr_data2 = 8'h0F;
    @(posedge clk); #1 wr_en2 = 1'b0;
    capture(1, 10, 1'b1, got, sc);
    checks++;
    if (got[9:0] !== 10'b1_0000_1111_0) begin errors++; $display("FAIL np_frame0f: got %b want %b", got[9:0], 10'b1_0000_1111_0); end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_fifo_full();
    test_divisor();
    test_reset_midframe();
    test_no_parity();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
